// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM state encoding and the divide-by-zero quotient value.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Quotient written to LO when the divisor is zero.
  localparam logic [MD_WIDTH-1:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  // True for the multi-cycle operations (MULT/MULTU/DIV/DIVU).
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the iterative multiplier/divider.
// Multiply: acc = {partial_hi, multiplier_remaining}; conditional add of the
// multiplicand into the upper half, then shift right by one.
// Divide: acc = {remainder, dividend_remaining/quotient}; restoring
// shift-subtract, quotient bit shifted in at the bottom.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Compute both step flavours and select by is_div.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, operand};
    if (is_div) begin
      // diff[WIDTH] set means the trial subtraction went negative: restore.
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
// MULT/MULTU/DIV/DIVU work on operand magnitudes for WIDTH cycles, then a
// FIX cycle applies sign correction and writes HI/LO. MTHI/MTLO write in one
// cycle from IDLE.
//
// Handshake: start is a request that is consumed only at an edge where the
// unit is IDLE and flush is low. While busy, start is not consumed; stall is
// raised instead so the instruction holds in EX and is re-presented once
// busy falls. mf_req likewise stalls while busy so MFHI/MFLO never read a
// stale HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output muldiv_state_e    state_dbg
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_e      state;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;

  // Operand decode at issue.
  logic               signed_op;
  logic               is_div_op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Sign-corrected results presented in FIX.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  assign busy      = (state != IDLE);
  assign stall     = busy && (start || mf_req);
  assign state_dbg = state;

  // Issue-time decode: magnitudes and signs; unsigned ops pass raw values.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    sa        = signed_op && a[WIDTH-1];
    sb        = signed_op && b[WIDTH-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
  end

  // Final HI/LO values: negate magnitudes as needed; divide-by-zero override.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (div0) begin
      fix_hi = a_raw;
      fix_lo = {WIDTH{DIV0_LO[0]}};
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      acc     <= '0;
      operand <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Abort anything in flight; HI/LO untouched, no done.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (is_long_op(op)) begin
                state   <= CALC;
                counter <= '0;
                acc     <= {{WIDTH{1'b0}}, mag_a};
                operand <= mag_b;
                a_raw   <= a;
                is_div  <= is_div_op;
                neg_q   <= sa ^ sb;
                neg_r   <= sa;
                div0    <= is_div_op && (b == '0);
              end else if (op == OP_MTHI) begin
                hi <= a;
              end else if (op == OP_MTLO) begin
                lo <= a;
              end
            end
          end
          CALC: begin
            acc     <= acc_next;
            counter <= counter + CW'(1);
            if (counter == CW'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
          FIX: begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit. Expected HI/LO come from
// plain 64-bit arithmetic on the operands, queued at issue and popped at done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          mf_req;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  muldiv_state_e state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .mf_req    (mf_req),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Reference result {hi, lo} from the architectural definition.
  function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [2*W-1:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (o)
      OP_MULT:  p = 64'(sx * sy);
      OP_MULTU: p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      OP_DIV: begin
        if (y == '0) p = {x, {W{1'b1}}};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[W-1:0], q[W-1:0]};
        end
      end
      OP_DIVU: begin
        if (y == '0) p = {x, {W{1'b1}}};
        else p = {x % y, x / y};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic push_expected(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    r = ref_result(o, x, y);
    exp_q.push_back(r[2*W-1:W]);
    exp_q.push_back(r[W-1:0]);
  endtask

  // Called one edge after acceptance: counts busy cycles, then checks done/HI/LO.
  task automatic wait_done(input string tag);
    int cycles;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
    check({tag, " busy cycles"}, W'(cycles), W'(33));
    check({tag, " done"}, W'(done), W'(1));
    if (exp_q.size() >= 2) begin
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      m_hi = eh;
      m_lo = el;
    end
    tick();
    check({tag, " done pulse width"}, W'(done), W'(0));
  endtask

  task automatic run_long(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    push_expected(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [W-1:0] x);
    op = o; a = x; start = 1'b1;
    tick();
    start = 1'b0;
    if (o == OP_MTHI) m_hi = x;
    else m_lo = x;
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " busy"}, W'(busy), W'(0));
    check({tag, " done"}, W'(done), W'(0));
  endtask

  initial begin
    int cycles;
    logic flag;
    logic [2:0] o;
    logic [W-1:0] x;
    logic [W-1:0] y;

    // Reset
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0; mf_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset stall", W'(stall), W'(0));
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);

    // Directed arithmetic
    run_long("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult -3*5 const hi", hi, 32'hFFFF_FFFF);
    check("mult -3*5 const lo", lo, 32'hFFFF_FFF1);
    run_long("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd5);
    check("multu const hi", hi, 32'h0000_0004);
    run_long("divu 100/7", OP_DIVU, 32'd100, 32'd7);
    check("divu const lo", lo, 32'd14);
    check("divu const hi", hi, 32'd2);
    run_long("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 const lo", lo, 32'hFFFF_FFFD);
    run_long("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div overflow const lo", lo, 32'h8000_0000);
    check("div overflow const hi", hi, 32'h0);
    run_long("div by zero", OP_DIV, 32'h0000_1234, 32'd0);
    check("div0 const lo", lo, 32'hFFFF_FFFF);
    check("div0 const hi", hi, 32'h0000_1234);
    run_long("div by zero neg", OP_DIV, 32'h8765_4321, 32'd0);
    run_long("divu by zero", OP_DIVU, 32'hDEAD_BEEF, 32'd0);

    // MTHI then MTLO on consecutive cycles
    run_mt("mthi", OP_MTHI, 32'hAAAA_0000);
    run_mt("mtlo", OP_MTLO, 32'h0000_5555);

    // Undefined op codes are ignored
    op = 3'd6; a = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("undef op busy", W'(busy), W'(0));
    check("undef op hi", hi, m_hi);
    check("undef op lo", lo, m_lo);

    // Start held during busy with mf_req: stalls, then accepted as busy falls
    push_expected(OP_MULT, 32'd6, 32'd7);
    op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    op = OP_DIVU; a = 32'd100; b = 32'd7; mf_req = 1'b1;
    flag = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      if (stall !== 1'b1) flag = 1'b0;
      cycles++;
      tick();
    end
    check("stall held while busy", W'(flag), W'(1));
    check("stall busy cycles", W'(cycles), W'(33));
    check("stall first done", W'(done), W'(1));
    check("stall first lo", lo, exp_q.pop_front() == 32'd0 ? exp_q.pop_front() : 32'hBAD0_BAD0);
    check("stall first lo const", lo, 32'd42);
    check("stall idle stall", W'(stall), W'(0));
    push_expected(OP_DIVU, 32'd100, 32'd7);
    tick();
    start = 1'b0; mf_req = 1'b0;
    check("divu accepted after busy", W'(busy), W'(1));
    wait_done("held divu");

    // Flush at cycle 10 of a DIV
    run_mt("mthi 11", OP_MTHI, 32'h11);
    run_mt("mtlo 11", OP_MTLO, 32'h11);
    op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", W'(busy), W'(0));
    flag = 1'b0;
    repeat (30) begin
      if (done !== 1'b0) flag = 1'b1;
      tick();
    end
    check("flush no done", W'(flag), W'(0));
    check("flush hi", hi, m_hi);
    check("flush lo", lo, m_lo);

    // Flush landing on the FIX edge suppresses the write
    op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush fix done", W'(done), W'(0));
    check("flush fix busy", W'(busy), W'(0));
    check("flush fix lo", lo, m_lo);

    // Flush together with start in IDLE
    op = OP_MTHI; a = 32'hCAFE_F00D; start = 1'b1; flush = 1'b1;
    tick();
    op = OP_DIV;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", W'(busy), W'(0));
    check("flush+start hi", hi, m_hi);

    // Reset mid-operation at cycle 20
    op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("mid reset busy", W'(busy), W'(0));
    check("mid reset done", W'(done), W'(0));
    check("mid reset hi", hi, '0);
    check("mid reset lo", lo, '0);
    tick();
    check("mid reset stays idle", W'(busy), W'(0));

    // Randomized long ops interleaved with MTHI/MTLO
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = W'($urandom_range(1, 15));
        2: x = W'($urandom_range(0, 1000));
        default: ;
      endcase
      run_long("random", o, x, y);
      if ($urandom_range(0, 3) == 0) begin
        run_mt("random mt", ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
